deserializer_param: RTL and testbench

- Parametrised 1:N serial-to-parallel converter; next generation of the team's 1:8 deserializer.
- Captures LANES bits per clock from 1..4 serial lanes and assembles WIDTH-bit words.
- Supports selectable bit order, partial-word flush, and a registered output with valid/ready handshake and overrun detection.
- Sits between the lane receivers (post-CDC, same clock) and the packet/byte-level layers.

---
 rtl/deserializer_param.sv | 155 +++++++++++++++
 tb/tb_deserializer_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_param.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_param
// Description : Parametrised 1:N serial-to-parallel converter. Collects LANES
//               bits per valid beat into WIDTH-bit words. The bit order is
//               selectable. A partial word can be flushed. Completed words are
//               presented on a registered valid/ready output slot, and a
//               sticky overrun flag reports words dropped while the slot was
//               busy.
//               Optional build macro DESERIALIZER_PARAM_SYNC_DETECT_EN adds
//               a HUNT/ALIGNED state machine. In HUNT the block searches for
//               SYNC_WORD before it assembles any word, and it drives an
//               extra `aligned` output.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_param #(
    parameter int               WIDTH     = 8,
    parameter int               LANES     = 1,
    parameter int               MSB_FIRST = 0,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hB8)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES-1:0]                datain,
    input  logic                            validIn,
    input  logic                            flush,
    output logic [WIDTH-1:0]                dataout,
    output logic                            validOut,
    input  logic                            readyIn,
    output logic                            overrun,
    output logic [$clog2(WIDTH/LANES)-1:0]  beat_cnt
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
    ,
    output logic                            aligned
`endif
);

    localparam int                 c_BEATS     = WIDTH / LANES;
    localparam int                 c_CNT_W     = $clog2(c_BEATS);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    logic [WIDTH-1:0]   r_sr;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [WIDTH-1:0]   r_dataout;
    logic               r_valid_out;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_shifted;     // shift register contents after this beat
    logic               w_hunt;        // still searching for alignment
    logic               w_complete;    // this beat closes a word
    logic               w_slot_free;   // output slot can take a new word

    // The shift direction sets which end of the word the first bit lands in.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            logic [LANES-1:0] w_din_rev;
            for (genvar i = 0; i < LANES; i++) begin : g_rev
                assign w_din_rev[i] = datain[LANES-1-i];
            end
            assign w_shifted = {r_sr[WIDTH-LANES-1:0], w_din_rev};
            // The oldest lane group falls off the top and is never read.
            logic w_unused_head;
            assign w_unused_head = ^r_sr[WIDTH-1:WIDTH-LANES];
        end else begin : g_lsb_first
            assign w_shifted = {datain, r_sr[WIDTH-1:LANES]};
            // The oldest lane group falls off the bottom and is never read.
            logic w_unused_tail;
            assign w_unused_tail = ^r_sr[LANES-1:0];
        end
    endgenerate

`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_sync_hit;

    // A match is checked on every accepted beat, using the post-shift window.
    assign w_sync_hit = validIn && !flush && (w_shifted == SYNC_WORD);

    // State register: reset always returns to HUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: lock on the sync word, and fall back to HUNT on flush.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HUNT:    if (w_sync_hit) w_state_next = ALIGNED;
            ALIGNED: if (flush)      w_state_next = HUNT;
            default: w_state_next = HUNT;
        endcase
    end

    assign w_hunt  = (r_state == HUNT);
    assign aligned = (r_state == ALIGNED);
`else
    // Without alignment hunting, capture is word-aligned from the first beat.
    assign w_hunt = 1'b0;
    logic w_unused_sync;
    assign w_unused_sync = ^SYNC_WORD;
`endif

    assign w_complete  = validIn && !flush && !w_hunt && (r_beat_cnt == c_LAST_BEAT);
    assign w_slot_free = !r_valid_out || readyIn;

    // Capture path: shift accepted beats in and count them; flush clears both.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_sr       <= '0;
            r_beat_cnt <= '0;
        end else if (validIn) begin
            r_sr <= w_shifted;
            if (w_hunt || w_complete) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Output slot: load completed words, retire on handshake, flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataout   <= '0;
            r_valid_out <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_complete) begin
            if (w_slot_free) begin
                r_dataout   <= w_shifted;
                r_valid_out <= 1'b1;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (r_valid_out && readyIn) begin
            r_valid_out <= 1'b0;
        end
    end

    assign dataout  = r_dataout;
    assign validOut = r_valid_out;
    assign overrun  = r_overrun;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer_param
// Description : Directed self-checking bench for deserializer_param. It
//               drives three configurations (8x1 LSB-first, 8x1 MSB-first,
//               16x4 LSB-first) from shared control inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer_param;

    logic        clk;
    logic        rst;
    logic        validIn;
    logic        flush;
    logic        readyIn;
    logic        d1;
    logic [3:0]  d4;

    logic [7:0]  a_dout;
    logic        a_vo;
    logic        a_ovr;
    logic [2:0]  a_cnt;
    logic [7:0]  b_dout;
    logic        b_vo;
    logic        b_ovr;
    logic [2:0]  b_cnt;
    logic [15:0] c_dout;
    logic        c_vo;
    logic        c_ovr;
    logic [1:0]  c_cnt;
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
    logic        a_al;
    logic        b_al;
    logic        c_al;
`endif

    int vectors;
    int miscompares;

    deserializer_param #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst(rst), .datain(d1), .validIn(validIn), .flush(flush),
        .dataout(a_dout), .validOut(a_vo), .readyIn(readyIn),
        .overrun(a_ovr), .beat_cnt(a_cnt)
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
        , .aligned(a_al)
`endif
    );

    deserializer_param #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .datain(d1), .validIn(validIn), .flush(flush),
        .dataout(b_dout), .validOut(b_vo), .readyIn(readyIn),
        .overrun(b_ovr), .beat_cnt(b_cnt)
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
        , .aligned(b_al)
`endif
    );

    deserializer_param #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .datain(d4), .validIn(validIn), .flush(flush),
        .dataout(c_dout), .validOut(c_vo), .readyIn(readyIn),
        .overrun(c_ovr), .beat_cnt(c_cnt)
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
        , .aligned(c_al)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat1(input logic b);
        d1 = b; validIn = 1'b1;
        step();
        validIn = 1'b0;
    endtask

    task automatic beat4(input logic [3:0] n);
        d4 = n; validIn = 1'b1;
        step();
        validIn = 1'b0;
    endtask

    task automatic word1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) beat1(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        d1 = 1'b1; d4 = 4'hF; validIn = 1'b1; readyIn = 1'b1; rst = 1'b1;
        step(); step();
        rst = 1'b0; validIn = 1'b0;
        vectors++; if (a_dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", a_dout); end
        vectors++; if (a_vo !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", a_vo); end
        vectors++; if (a_ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b exp=0", a_ovr); end
        vectors++; if (a_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
        vectors++; if (c_cnt !== 2'd0 || c_vo !== 1'b0) begin miscompares++; $display("FAIL reset_c got cnt=%0d vo=%b exp 0/0", c_cnt, c_vo); end
    endtask

    task automatic test_bit_order();
        logic [7:0] pat;
        pat = 8'h8D;                      // bits in time order 1,0,1,1,0,0,0,1
        do_reset();
        readyIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat1(pat[i]);
            if (i == 2) begin
                vectors++; if (a_cnt !== 3'd3) begin miscompares++; $display("FAIL order_cnt3 got=%0d exp=3", a_cnt); end
            end
            if (i == 6) begin
                vectors++; if (a_vo !== 1'b0) begin miscompares++; $display("FAIL order_early_valid got=%b exp=0", a_vo); end
            end
        end
        vectors++; if (a_vo !== 1'b1) begin miscompares++; $display("FAIL order_valid got=%b exp=1", a_vo); end
        vectors++; if (a_dout !== 8'h8D) begin miscompares++; $display("FAIL lsb_first_word got=%h exp=8d", a_dout); end
        vectors++; if (b_dout !== 8'hB1) begin miscompares++; $display("FAIL msb_first_word got=%h exp=b1", b_dout); end
        vectors++; if (a_cnt !== 3'd0 || b_cnt !== 3'd0) begin miscompares++; $display("FAIL order_cnt_wrap got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
        step();
        vectors++; if (a_vo !== 1'b0 || b_vo !== 1'b0) begin miscompares++; $display("FAIL order_pulse got=%b/%b exp=0/0", a_vo, b_vo); end
        vectors++; if (a_dout !== 8'h8D) begin miscompares++; $display("FAIL order_hold_dout got=%h exp=8d", a_dout); end
    endtask

    task automatic test_lane_gap();
        do_reset();
        readyIn = 1'b1;
        beat4(4'h1);
        beat4(4'h2);
        vectors++; if (c_cnt !== 2'd2) begin miscompares++; $display("FAIL gap_cnt got=%0d exp=2", c_cnt); end
        step(); step(); step();
        vectors++; if (c_cnt !== 2'd2 || c_vo !== 1'b0) begin miscompares++; $display("FAIL gap_hold got cnt=%0d vo=%b exp 2/0", c_cnt, c_vo); end
        beat4(4'h3);
        beat4(4'h4);
        vectors++; if (c_vo !== 1'b1) begin miscompares++; $display("FAIL gap_valid got=%b exp=1", c_vo); end
        vectors++; if (c_dout !== 16'h4321) begin miscompares++; $display("FAIL gap_word got=%h exp=4321", c_dout); end
        step();
        vectors++; if (c_vo !== 1'b0) begin miscompares++; $display("FAIL gap_pulse got=%b exp=0", c_vo); end
    endtask

    task automatic test_overrun();
        do_reset();
        readyIn = 1'b0;
        word1(8'h8D);
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'h8D || a_ovr !== 1'b0) begin miscompares++; $display("FAIL ovr_first got vo=%b d=%h o=%b exp 1/8d/0", a_vo, a_dout, a_ovr); end
        word1(8'h5A);
        vectors++; if (a_dout !== 8'h8D || a_vo !== 1'b1) begin miscompares++; $display("FAIL ovr_held got vo=%b d=%h exp 1/8d", a_vo, a_dout); end
        vectors++; if (a_ovr !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got=%b exp=1", a_ovr); end
        readyIn = 1'b1;
        step();
        vectors++; if (a_vo !== 1'b0 || a_dout !== 8'h8D) begin miscompares++; $display("FAIL ovr_transfer got vo=%b d=%h exp 0/8d", a_vo, a_dout); end
        step(); step(); step();
        vectors++; if (a_ovr !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got=%b exp=1", a_ovr); end
        do_reset();
        vectors++; if (a_ovr !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got=%b exp=0", a_ovr); end
    endtask

    task automatic test_flush();
        do_reset();
        readyIn = 1'b1;
        for (int i = 0; i < 5; i++) beat1(1'b0);
        vectors++; if (a_cnt !== 3'd5) begin miscompares++; $display("FAIL flush_pre_cnt got=%0d exp=5", a_cnt); end
        flush = 1'b1; d1 = 1'b1; validIn = 1'b1;
        step();
        flush = 1'b0; validIn = 1'b0;
        vectors++; if (a_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_cnt got=%0d exp=0", a_cnt); end
        for (int i = 0; i < 3; i++) beat1(1'b1);
        vectors++; if (a_vo !== 1'b0) begin miscompares++; $display("FAIL flush_stale_word got=%b exp=0", a_vo); end
        for (int i = 0; i < 5; i++) beat1(1'b1);
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'hFF) begin miscompares++; $display("FAIL flush_word got vo=%b d=%h exp 1/ff", a_vo, a_dout); end
        step();
        // A flush on the completing beat discards that word.
        for (int i = 0; i < 7; i++) beat1(1'b0);
        flush = 1'b1; d1 = 1'b0; validIn = 1'b1;
        step();
        flush = 1'b0; validIn = 1'b0;
        vectors++; if (a_vo !== 1'b0 || a_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_on_last got vo=%b cnt=%0d exp 0/0", a_vo, a_cnt); end
        // A flush leaves a pending output word alone.
        readyIn = 1'b0;
        word1(8'h3C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'h3C) begin miscompares++; $display("FAIL flush_keeps_out got vo=%b d=%h exp 1/3c", a_vo, a_dout); end
        readyIn = 1'b1;
        step();
        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) beat1(1'b1);
        vectors++; if (a_cnt !== 3'd3) begin miscompares++; $display("FAIL midword_cnt got=%0d exp=3", a_cnt); end
        do_reset();
        vectors++; if (a_dout !== 8'h00 || a_vo !== 1'b0 || a_cnt !== 3'd0 || a_ovr !== 1'b0) begin miscompares++; $display("FAIL midword_reset got d=%h vo=%b cnt=%0d o=%b exp 00/0/0/0", a_dout, a_vo, a_cnt, a_ovr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [7:0]  w3;
        stream = 16'h3CA5;                // A5 first, then 3C
        w3 = 8'hC3;
        do_reset();
        readyIn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beat1(stream[i]);
            if (i == 7) begin
                vectors++; if (a_vo !== 1'b1 || a_dout !== 8'hA5) begin miscompares++; $display("FAIL b2b_w1 got vo=%b d=%h exp 1/a5", a_vo, a_dout); end
            end
            if (i == 8) begin
                vectors++; if (a_vo !== 1'b0) begin miscompares++; $display("FAIL b2b_drop got=%b exp=0", a_vo); end
            end
        end
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'h3C) begin miscompares++; $display("FAIL b2b_w2 got vo=%b d=%h exp 1/3c", a_vo, a_dout); end
        // Transfer and completion in the same cycle: new word, no bubble.
        readyIn = 1'b0;
        for (int i = 0; i < 7; i++) beat1(w3[i]);
        readyIn = 1'b1;
        beat1(w3[7]);
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'hC3 || a_ovr !== 1'b0) begin miscompares++; $display("FAIL b2b_same_cycle got vo=%b d=%h o=%b exp 1/c3/0", a_vo, a_dout, a_ovr); end
    endtask

`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
    task automatic test_sync();
        logic [7:0] sw;
        logic [7:0] pay;
        sw  = 8'hB8;
        pay = 8'h5A;
        do_reset();
        readyIn = 1'b1;
        vectors++; if (a_al !== 1'b0) begin miscompares++; $display("FAIL sync_reset got=%b exp=0", a_al); end
        beat1(1'b1); beat1(1'b0); beat1(1'b1);
        for (int i = 0; i < 8; i++) begin
            beat1(sw[i]);
            if (i == 6) begin
                vectors++; if (a_al !== 1'b0) begin miscompares++; $display("FAIL sync_early got=%b exp=0", a_al); end
            end
        end
        vectors++; if (a_al !== 1'b1 || a_vo !== 1'b0 || a_cnt !== 3'd0) begin miscompares++; $display("FAIL sync_lock got al=%b vo=%b cnt=%0d exp 1/0/0", a_al, a_vo, a_cnt); end
        word1(pay);
        vectors++; if (a_vo !== 1'b1 || a_dout !== 8'h5A) begin miscompares++; $display("FAIL sync_payload got vo=%b d=%h exp 1/5a", a_vo, a_dout); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (a_al !== 1'b0) begin miscompares++; $display("FAIL sync_flush got=%b exp=0", a_al); end
    endtask
`endif

    // Test sequence.
    initial begin
        vectors = 0; miscompares = 0;
        clk = 1'b0; rst = 1'b1; validIn = 1'b0; flush = 1'b0; readyIn = 1'b0;
        d1 = 1'b0; d4 = 4'h0;
        test_reset();
`ifdef DESERIALIZER_PARAM_SYNC_DETECT_EN
        test_sync();
`else
        test_bit_order();
        test_lane_gap();
        test_overrun();
        test_flush();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
